// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the AXI4-Lite I/O responder.
//   - Register map addresses (RX data, TX data, STATUS)
//   - AXI response codes
//   - Write / read FSM state encodings
//   - status_word(): packs the STATUS register
package io_pkg;

    localparam logic [3:0] IO_ADDR_RX   = 4'h0;
    localparam logic [3:0] IO_ADDR_TX   = 4'h4;
    localparam logic [3:0] IO_ADDR_STAT = 4'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    // STATUS: bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, rest zero.
    function automatic logic [31:0] status_word(input logic rx_nonempty,
                                                input logic tx_full,
                                                input logic tx_empty);
        return {29'd0, tx_empty, tx_full, rx_nonempty};
    endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: first-word-fall-through FIFO used for both byte directions.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, din    write request and data; refused while full
//   pop          read request; ignored while empty
//   dout         head entry (valid whenever !empty)
//   full, empty  occupancy flags
// Parameters: DEPTH (power of two, >= 2), WIDTH.
module io_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_axil_responder.sv
// io_axil_responder: AXI4-Lite responder bridging register accesses to a
// TX and an RX byte stream, each buffered by an io_fifo.
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*          write address, data, response channels
//   S_AXI_AR*/R*             read address, data channels
//   TX_DATA/VALID/READY      outgoing byte stream (TX FIFO head)
//   RX_DATA/VALID/READY      incoming byte stream (into RX FIFO)
// Register map: 0x0 RX pop, 0x4 TX push (WSTB[0]), 0x8 STATUS, others SLVERR.
// Build option: define IO_BLOCKING_EN to stall W_EXEC on a full TX FIFO and
// R_EXEC on an empty RX FIFO instead of answering SLVERR.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both 1. A source holds VALID and its payload stable until that edge; this
// block's VALID outputs and their payloads are registered and only change on
// the accepting edge.
module io_axil_responder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [3:0]  S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY
);

    import io_pkg::*;

    // Held low through reset so no address channel is accepted before the
    // first edge after RST_N releases.
    logic ready_q;

    // TX / RX FIFO wiring
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;

    // Write path state
    w_state_e   w_state_q;
    logic       aw_cap_q, w_cap_q;
    logic [3:0] waddr_q;
    logic [7:0] wbyte_q;
    logic       wstb0_q;
    logic       bvalid_q;
    logic [1:0] bresp_q;
    logic       aw_hs, w_hs, w_tx_req, w_stall;
    logic [1:0] w_resp_sel;

    // Read path state
    r_state_e    r_state_q;
    logic [3:0]  raddr_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs, r_stall;
    logic [31:0] r_data_sel;
    logic [1:0]  r_resp_sel;

    // Only the low data byte and its strobe reach the TX stream.
    logic unused_wbits;
    assign unused_wbits = ^{S_AXI_WDATA[31:8], S_AXI_WSTB[3:1]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wbyte_q),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (RX_DATA),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Stream side
    assign TX_VALID = !tx_empty;
    assign TX_DATA  = tx_dout;
    assign tx_pop   = TX_VALID && TX_READY;
    assign RX_READY = ready_q && !rx_full;
    assign rx_push  = RX_VALID && RX_READY;

    // ---------------- Write path ----------------
    assign S_AXI_AWREADY = ready_q && (w_state_q == W_IDLE) && !aw_cap_q;
    assign S_AXI_WREADY  = ready_q && (w_state_q == W_IDLE) && !w_cap_q;
    assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;

    assign w_tx_req = (waddr_q == IO_ADDR_TX) && wstb0_q;
    assign tx_push  = (w_state_q == W_EXEC) && w_tx_req && !tx_full;

`ifdef IO_BLOCKING_EN
    assign w_stall = w_tx_req && tx_full;
`else
    assign w_stall = 1'b0;
`endif

    // A full TX FIFO only yields SLVERR when not stalling; with stalling the
    // FSM leaves W_EXEC only once the push succeeds, so the response is OKAY.
    always_comb begin
        w_resp_sel = RESP_OKAY;
        case (waddr_q)
            IO_ADDR_RX, IO_ADDR_STAT: w_resp_sel = RESP_OKAY;
            IO_ADDR_TX: if (w_tx_req && tx_full) w_resp_sel = RESP_SLVERR;
            default:    w_resp_sel = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_state_q <= W_IDLE;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            waddr_q   <= '0;
            wbyte_q   <= '0;
            wstb0_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) waddr_q <= S_AXI_AWADDR;
                    if (w_hs) begin
                        wbyte_q <= S_AXI_WDATA[7:0];
                        wstb0_q <= S_AXI_WSTB[0];
                    end
                    // AW and W may arrive in either order or together.
                    if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
                        aw_cap_q  <= 1'b0;
                        w_cap_q   <= 1'b0;
                        w_state_q <= W_EXEC;
                    end else begin
                        aw_cap_q <= aw_cap_q || aw_hs;
                        w_cap_q  <= w_cap_q || w_hs;
                    end
                end
                W_EXEC: begin
                    if (!w_stall) begin
                        bresp_q   <= w_resp_sel;
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- Read path ----------------
    assign S_AXI_ARREADY = ready_q && (r_state_q == R_IDLE);
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign rx_pop = (r_state_q == R_EXEC) && (raddr_q == IO_ADDR_RX) && !rx_empty;

`ifdef IO_BLOCKING_EN
    assign r_stall = (raddr_q == IO_ADDR_RX) && rx_empty;
`else
    assign r_stall = 1'b0;
`endif

    always_comb begin
        r_data_sel = '0;
        r_resp_sel = RESP_OKAY;
        case (raddr_q)
            IO_ADDR_RX: begin
                if (rx_empty) r_resp_sel = RESP_SLVERR;
                else          r_data_sel = {24'd0, rx_dout};
            end
            IO_ADDR_TX:   r_data_sel = '0;
            IO_ADDR_STAT: r_data_sel = status_word(!rx_empty, tx_full, tx_empty);
            default:      r_resp_sel = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        raddr_q   <= S_AXI_ARADDR;
                        r_state_q <= R_EXEC;
                    end
                end
                R_EXEC: begin
                    if (!r_stall) begin
                        rdata_q   <= r_data_sel;
                        rresp_q   <= r_resp_sel;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_axil_responder.sv
// tb_io_axil_responder: directed bench for io_axil_responder.
// Expected values are hand-computed; TX bytes are tracked in exp_q.
// Build option IO_BLOCKING_EN selects the stalling expectations.
module tb_io_axil_responder;

    localparam int DEPTH = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    io_axil_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTB    (wstb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .TX_DATA       (tx_data),
        .TX_VALID      (tx_valid),
        .TX_READY      (tx_ready),
        .RX_DATA       (rx_data),
        .RX_VALID      (rx_valid),
        .RX_READY      (rx_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // AW is presented aw_delay cycles after W; BREADY held low for hold cycles.
    // lat counts sampled cycles from the completing handshake edge to BVALID.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int hold,
                             input logic [1:0] exp_resp, input int exp_lat, input string tag);
        logic aw_done, w_done, aw_hs, w_hs;
        logic [1:0] resp0;
        int n, lat;
        awaddr = addr; wdata = data; wstb = strb;
        wvalid = 1'b1; awvalid = (aw_delay == 0);
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 100) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1; n++;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            if (!aw_done && n >= aw_delay) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, "_hs"}, {aw_done, w_done}, 2'b11);
        lat = 1;
        while (!bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_bresp"}, bresp, exp_resp);
        resp0 = bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_bvalid_hold"}, bvalid, 1'b1);
            check({tag, "_bresp_hold"}, bresp, resp0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check({tag, "_bvalid_drop"}, bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int exp_lat, input int hold,
                            input string tag);
        logic done, hs;
        logic [31:0] d0;
        logic [1:0] r0;
        int n, lat;
        araddr = addr; arvalid = 1'b1; done = 1'b0; n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1; n++;
            if (hs) begin done = 1'b1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        check({tag, "_ar_hs"}, done, 1'b1);
        lat = 1;
        while (!rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, rresp, exp_resp);
        d0 = rdata; r0 = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_rvalid_hold"}, rvalid, 1'b1);
            check({tag, "_rdata_hold"}, rdata, d0);
            check({tag, "_rresp_hold"}, rresp, r0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check({tag, "_rvalid_drop"}, rvalid, 1'b0);
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        check("rx_ready_send", rx_ready, 1'b1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Pops every byte in exp_q from the TX stream, then expects it empty.
    task automatic drain_tx(input string tag);
        int guard;
        guard = 0;
        tx_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge clk);
            if (tx_valid) check({tag, "_txdata"}, tx_data, exp_q.pop_front());
            @(posedge clk); #1; guard++;
        end
        tx_ready = 1'b0;
        check({tag, "_tx_empty"}, tx_valid, 1'b0);
        check({tag, "_q_left"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resps", {bresp, rresp}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_awready_pre_edge", awready, 1'b0);
        check("rel_rx_ready_pre_edge", rx_ready, 1'b0);
        @(posedge clk); #1;
        check("rel_awready", awready, 1'b1);
        check("rel_wready", wready, 1'b1);
        check("rel_arready", arready, 1'b1);
        check("rel_rx_ready", rx_ready, 1'b1);

        // Basic TX write then STATUS
        axi_write(4'h4, 32'h41, 4'hF, 0, 0, OKAY, 2, "wr_tx41");
        exp_q.push_back(8'h41);
        check("tx41_data", tx_data, 8'h41);
        check("tx41_valid", tx_valid, 1'b1);
        axi_read(4'h8, 32'h0, OKAY, 2, 0, "stat_tx1");
        drain_tx("drain1");

        // RX byte, STATUS before/after the pop
        rx_send(8'h5A);
        axi_read(4'h8, 32'h5, OKAY, 2, 0, "stat_rx1");
        axi_read(4'h0, 32'h5A, OKAY, 2, 0, "rd_rx5a");
        axi_read(4'h8, 32'h4, OKAY, 2, 0, "stat_rx0");

        // No-push and ignored accesses
        axi_write(4'h4, 32'h99, 4'hE, 0, 0, OKAY, 2, "wr_nostb");
        axi_write(4'h0, 32'h12, 4'hF, 0, 0, OKAY, 2, "wr_rx_ign");
        axi_read(4'h4, 32'h0, OKAY, 2, 0, "rd_tx");
        check("no_push_tx_valid", tx_valid, 1'b0);

        // W first, AW three cycles later, BREADY held low
        axi_write(4'h4, 32'hABCDEF77, 4'h1, 3, 4, OKAY, 2, "wr_wfirst");
        exp_q.push_back(8'h77);
        drain_tx("drain_wfirst");

        // Fill TX with TX_READY low
        for (int i = 0; i < DEPTH; i++) begin
            axi_write(4'h4, 32'h10 + i, 4'hF, 0, 0, OKAY, 2, "wr_fill");
            exp_q.push_back(8'(8'h10 + i));
        end
        axi_read(4'h8, 32'h2, OKAY, 2, 0, "stat_full");
`ifdef IO_BLOCKING_EN
        fork
            axi_write(4'h4, 32'h18, 4'hF, 0, 0, OKAY, 8, "wr_9th_block");
            begin
                repeat (6) @(posedge clk);
                #1;
                tx_ready = 1'b1;
                @(negedge clk);
                check("block_pop_one", tx_data, exp_q.pop_front());
                @(posedge clk); #1;
                tx_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h18);
`else
        axi_write(4'h4, 32'h18, 4'hF, 0, 0, SLVERR, 2, "wr_9th_drop");
`endif
        drain_tx("drain_full");

        // RX read with RX empty
`ifdef IO_BLOCKING_EN
        fork
            axi_read(4'h0, 32'h33, OKAY, 5, 0, "rd_rx_block");
            begin
                repeat (3) @(posedge clk);
                #1;
                rx_data = 8'h33; rx_valid = 1'b1;
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
        join
`else
        axi_read(4'h0, 32'h0, SLVERR, 2, 0, "rd_rx_empty");
`endif

        // Unmapped addresses and read payload stability
        axi_read(4'hC, 32'h0, SLVERR, 2, 0, "rd_0c");
        axi_read(4'h1, 32'h0, SLVERR, 2, 0, "rd_01");
        axi_write(4'hC, 32'h5, 4'hF, 0, 0, SLVERR, 2, "wr_0c");
        rx_send(8'hC3);
        axi_read(4'h0, 32'hC3, OKAY, 2, 3, "rd_hold");

        // Reset while a write sits in W_RESP
        rx_send(8'h7E);
        axi_write(4'h4, 32'h55, 4'hF, 0, 0, OKAY, 2, "wr_pre_rst");
        awaddr = 4'h4; wdata = 32'h66; wstb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_bvalid_before_rst", bvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_awready", awready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_awready_pre_edge", awready, 1'b0);
        @(posedge clk); #1;
        check("mid_rel_awready", awready, 1'b1);
        check("mid_rel_bvalid", bvalid, 1'b0);
        axi_read(4'h8, 32'h4, OKAY, 2, 0, "stat_post_rst");
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_bvalid", bvalid, 1'b0);
        check("post_rst_no_rvalid", rvalid, 1'b0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
